downsizer_arb: RTL and testbench
================================

Name: downsizer_arb

Overview:
Round-robin scheduler that shares one downsizer (wide word in, RATIO narrow beats out) between NUM_REQ wide-word producers. It selects a requester, issues one registered valid_in pulse plus data to the downsizer, and paces issues so each word is accepted exactly when the downsizer's beat counter is idle. It also tags the downsizer's output beat stream with source ID and last-beat flag for downstream demux.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
INP_DATA_WIDTH, 128, wide word width in bytes (bits = INP_DATA_WIDTH*8)
DATA_OUT_WIDTH, 32, narrow beat width in bytes
RATIO, INP_DATA_WIDTH/DATA_OUT_WIDTH, beats per word; power of 2, >=2
ID_WIDTH, $clog2(NUM_REQ), source-ID width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  1 = new issues allowed; 0 = finish in-flight word, issue nothing new
req  in  NUM_REQ  per-requester request; held with data until its gnt pulse
req_data  in  NUM_REQ*INP_DATA_WIDTH*8  packed words, requester i at slice i
gnt  out  NUM_REQ  one-hot, one-cycle pulse: word from that requester taken this cycle
ds_valid_in  out  1  to downsizer valid_in
ds_inp_data  out  INP_DATA_WIDTH*8  to downsizer inp_data
ds_out_en  in  1  from downsizer out_en
out_src_id  out  ID_WIDTH  source of beat currently on downsizer data_out
out_last  out  1  ds_out_en high and current beat is final beat of its word
busy  out  1  word issued, issue window not yet reopened

Behaviour:
- Reset (async, rst=1): gnt=0, ds_valid_in=0, ds_inp_data=0, out_src_id=0, busy=0, state IDLE, issue counter=0, beat counter=0, RR pointer=0. Downsizer held in reset by same event; mid-word reset drops the word, no gnt replay.
- States IDLE, BUSY.
- IDLE, enable=1, |req=1: winner = first set req at or after RR pointer, cyclic. Same edge register: ds_valid_in=1, ds_inp_data=req_data[winner], gnt=onehot(winner), issued_src=winner, issue counter=RATIO-1, pointer=(winner+1) mod NUM_REQ, go BUSY, busy=1.
- IDLE, no req or enable=0: outputs low, pointer unchanged.
- BUSY: ds_valid_in, gnt cleared next edge (1-cycle pulses); counter decrements each cycle; counter 1->0 returns to IDLE, busy=0.
- Issue spacing exactly RATIO cycles under continuous requests; never fewer (downsizer would drop the word), one word in flight at a time.
- gnt and ds_valid_in assert in the same cycle, always together.
- Requester drops req without gnt: ignored, no error. req sampled only in IDLE.
- enable deasserted in BUSY: in-flight word completes; no issue until enable=1 in IDLE.
- Tagging: on every edge where ds_valid_in=1, out_src_id <= issued_src (valid from first output beat). Beat counter (log2 RATIO bits) increments on each ds_out_en cycle, wraps at RATIO; out_last = ds_out_en && beat counter==RATIO-1 (combinational from registers). Continuous back-to-back words keep ds_out_en high; counter wrap gives correct framing.
- Downsizer emits beats in cycles 2..RATIO+1 after ds_valid_in rises; block needs no knowledge of beat order.
- Pointer update uses winner, not old pointer (strict RR fairness; no requester waits more than NUM_REQ-1 grants).

Test Plan:
- Reset: rst=1 mid-BUSY with req=4'b1111 -> all outputs 0 same cycle (async); after release, first gnt=4'b0001.
- Single req: req=4'b0100, data=D -> gnt=4'b0100, ds_valid_in=1 one cycle with ds_inp_data=D; 4 ds_out_en beats, out_src_id=2, out_last on 4th beat only.
- Continuous all-req: req=4'b1111 for 20 cycles -> gnt sequence 0001,0010,0100,1000,0001 spaced exactly 4 cycles; ds_out_en continuously high; out_last every 4th beat.
- Fairness skip: req=4'b1001, pointer at 1 -> gnt 1000 then 0001, no gaps beyond 4 cycles.
- enable drop: enable=0 one cycle after issue, req held -> in-flight 4 beats complete, no further ds_valid_in; enable=1 -> next issue next IDLE cycle.
- Late request: req rises while busy=1 -> not granted until counter reaches 0; gnt exactly 4 cycles after previous gnt.

Source files
------------

// File: rtl/downsizer_arb.sv
// downsizer_arb
// Round-robin scheduler that shares one wide-to-narrow downsizer between
// NUM_REQ wide-word producers. It issues one word at a time, as a one-cycle
// ds_valid_in pulse with a matching gnt pulse. Issues are spaced exactly
// RATIO cycles apart, so every word reaches the downsizer when its beat
// counter is idle. It also tags the narrow beat stream with the source ID
// and a last-beat flag.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   enable       1 = new issues allowed; 0 = let in-flight word finish only
//   req          per-requester request, held with its data until gnt
//   req_data     packed wide words, requester i at slice i
//   gnt          one-hot one-cycle pulse: word of that requester taken
//   ds_valid_in  to downsizer valid_in
//   ds_inp_data  to downsizer inp_data
//   ds_out_en    from downsizer out_en (beat present on its data_out)
//   out_src_id   source of the beat currently on the downsizer output
//   out_last     current downsizer beat is the final beat of its word
//   busy         a word was issued and the issue window is not yet reopened
module downsizer_arb #(
  parameter int NUM_REQ        = 4,
  parameter int INP_DATA_WIDTH = 128,
  parameter int DATA_OUT_WIDTH = 32,
  parameter int RATIO          = INP_DATA_WIDTH / DATA_OUT_WIDTH,
  parameter int ID_WIDTH       = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*INP_DATA_WIDTH*8-1:0] req_data,
  output logic [NUM_REQ-1:0]                gnt,
  output logic                              ds_valid_in,
  output logic [INP_DATA_WIDTH*8-1:0]       ds_inp_data,
  input  logic                              ds_out_en,
  output logic [ID_WIDTH-1:0]               out_src_id,
  output logic                              out_last,
  output logic                              busy
);

  localparam int DW = INP_DATA_WIDTH * 8;
  localparam int CW = $clog2(RATIO);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                valid_q, valid_d;
  logic [DW-1:0]       data_q, data_d;
  logic [ID_WIDTH-1:0] src_q, src_d;
  logic                busy_q, busy_d;
  logic [ID_WIDTH-1:0] out_src_q;
  logic [CW-1:0]       beat_q;

  // Unpack the requester words so the data mux is a plain array index.
  logic [DW-1:0] req_word [NUM_REQ];
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_word[gi] = req_data[gi*DW +: DW];
  end

  // Winner: first set request at or after the RR pointer, cyclically.
  logic                found;
  logic [ID_WIDTH-1:0] winner;
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    valid_d = 1'b0;
    data_d  = data_q;
    src_d   = src_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (enable && found) begin
          valid_d = 1'b1;
          gnt_d   = NUM_REQ'(1) << winner;
          data_d  = req_word[winner];
          src_d   = winner;
          cnt_d   = CW'(RATIO - 1);
          // Advance past the winner, not the old pointer, for strict fairness.
          ptr_d   = (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          state_d = BUSY;
          busy_d  = 1'b1;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        // Leaving on 1->0 reopens the window exactly RATIO cycles after issue.
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
    end
  end

  // Beat tagging. The source ID moves on the edge that hands the word to the
  // downsizer, so it is already valid for the first narrow beat. The beat
  // counter wraps naturally at RATIO (power of two), which keeps framing
  // correct across back-to-back words with ds_out_en held high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_src_q <= '0;
      beat_q    <= '0;
    end else begin
      if (valid_q) begin
        out_src_q <= src_q;
      end
      if (ds_out_en) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  assign gnt         = gnt_q;
  assign ds_valid_in = valid_q;
  assign ds_inp_data = data_q;
  assign out_src_id  = out_src_q;
  assign out_last    = ds_out_en && (beat_q == CW'(RATIO - 1));
  assign busy        = busy_q;

endmodule

// File: tb/tb_downsizer_arb.sv
// Bench for downsizer_arb: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a cycle-count
// model of the issue rules. A simple downsizer stand-in produces ds_out_en.
module tb_downsizer_arb;

  localparam int NR = 4;
  localparam int DW = 128 * 8;
  localparam int R  = 4;
  localparam int IW = 2;

  logic             clk;
  logic             rst;
  logic             enable;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    gnt;
  logic             ds_valid_in;
  logic [DW-1:0]    ds_inp_data;
  logic             ds_out_en;
  logic [IW-1:0]    out_src_id;
  logic             out_last;
  logic             busy;

  downsizer_arb dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .req_data(req_data),
    .gnt(gnt), .ds_valid_in(ds_valid_in), .ds_inp_data(ds_inp_data),
    .ds_out_en(ds_out_en), .out_src_id(out_src_id), .out_last(out_last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got ..%016h, expected ..%016h (t=%0t)", nm, act[63:0], exp[63:0], $time);
    end
  endtask

  // Downsizer stand-in: a word accepted on an edge yields R beats, one per
  // following cycle; held in reset together with the arbiter.
  int rem;
  always @(posedge clk or posedge rst) begin
    if (rst) rem <= 0;
    else if (ds_valid_in) rem <= R;
    else if (rem > 0) rem <= rem - 1;
  end
  assign ds_out_en = (rem != 0);

  // Reference model: edges are numbered; an issue may happen on edge n only
  // if at least R edges passed since the previous issue.
  logic [NR-1:0] m_gnt;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_src_out;
  logic          m_busy;
  int            m_ptr, m_last, m_edge, m_issue_src;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_gnt <= '0; m_valid <= 1'b0; m_data <= '0; m_src_out <= '0; m_busy <= 1'b0;
      m_ptr <= 0; m_last <= -1000; m_edge <= 0; m_issue_src <= 0;
    end else begin : model_step
      int n;
      int w;
      n = m_edge + 1;
      w = -1;
      m_edge  <= n;
      if (m_valid) m_src_out <= IW'(m_issue_src);
      m_gnt   <= '0;
      m_valid <= 1'b0;
      m_busy  <= (n - m_last) <= R - 2;
      if (enable && (req != '0) && (n - m_last) >= R) begin
        for (int k = 0; k < NR; k++) begin
          if (w < 0 && req[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
        end
        m_gnt       <= NR'(1) << w;
        m_valid     <= 1'b1;
        m_data      <= req_data[w*DW +: DW];
        m_issue_src <= w;
        m_ptr       <= (w + 1) % NR;
        m_last      <= n;
        m_busy      <= 1'b1;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt", 64'(gnt), 64'(m_gnt));
      chk("ds_valid_in", 64'(ds_valid_in), 64'(m_valid));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("out_src_id", 64'(out_src_id), 64'(m_src_out));
      chk("out_last", 64'(out_last), 64'(ds_out_en && rem == 1));
      if (m_valid) begin
        chk_data("ds_inp_data", ds_inp_data, m_data);
        $display("issue: gnt=%b src=%0d data=..%08h t=%0t", gnt, m_issue_src, ds_inp_data[31:0], $time);
      end
    end
  end

  task automatic rand_data();
    for (int i = 0; i < NR*DW/32; i++) req_data[i*32 +: 32] = $urandom;
  endtask

  logic [DW-1:0] d_word;
  int gl[$];
  int gt[$];
  int exp_cont[5] = '{8, 1, 2, 4, 8};
  int vcnt;
  bit found;

  initial begin
    rst = 1'b1; enable = 1'b1; req = '0; req_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single request from requester 2.
    rand_data();
    d_word = req_data[2*DW +: DW];
    req = 4'b0100;
    @(negedge clk);
    chk("single_gnt", 64'(gnt), 64'h4);
    chk("single_valid", 64'(ds_valid_in), 64'h1);
    chk_data("single_data", ds_inp_data, d_word);
    req = '0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("single_src", 64'(out_src_id), 64'h2);
      chk("single_last", 64'(out_last), 64'(j == 4));
    end

    // Continuous requests from all; pointer now at 3.
    req = 4'b1111;
    gl.delete(); gt.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt != '0) begin gl.push_back(int'(gnt)); gt.push_back(c); end
    end
    chk("cont_count", 64'(gl.size()), 64'd5);
    for (int i = 0; i < gl.size() && i < 5; i++) begin
      chk("cont_gnt", 64'(gl[i]), 64'(exp_cont[i]));
      if (i > 0) chk("cont_spacing", 64'(gt[i] - gt[i-1]), 64'd4);
    end

    // Asynchronous reset while a grant pulse is up.
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      if (gnt != '0) found = 1'b1;
    end
    chk("rst_wait_gnt", 64'(found), 64'h1);
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_valid", 64'(ds_valid_in), 64'h0);
    chk_data("rst_data", ds_inp_data, '0);
    chk("rst_src", 64'(out_src_id), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_first_gnt", 64'(gnt), 64'h1);

    // Fairness skip: pointer at 1, only 0 and 3 requesting.
    req = 4'b1001;
    gl.delete(); gt.delete();
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (gnt != '0) begin gl.push_back(int'(gnt)); gt.push_back(j); end
    end
    chk("fair_count", 64'(gl.size()), 64'd2);
    if (gl.size() == 2) begin
      chk("fair_gnt0", 64'(gl[0]), 64'h8);
      chk("fair_gnt1", 64'(gl[1]), 64'h1);
      chk("fair_t0", 64'(gt[0]), 64'd4);
      chk("fair_t1", 64'(gt[1]), 64'd8);
    end

    // enable dropped right after an issue; request stays up.
    enable = 1'b0;
    vcnt = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (ds_valid_in) vcnt++;
    end
    chk("en_drop_issues", 64'(vcnt), 64'd0);
    enable = 1'b1;
    @(negedge clk);
    chk("en_resume_gnt", 64'(gnt), 64'h8);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      req    = NR'($urandom);
      enable = ($urandom_range(0, 7) != 0);
      rand_data();
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
